rotor_position_bank: RTL and testbench

Holds the current letter position (0–25) of every rotor in the demo and sits directly downstream of the rotor-select capture and encoder-increment FSMs. It consumes the captured one-hot rotor select and single-cycle increment pulses, and applies each increment to the selected rotor with modulo-26 wrap. With stepping compiled in, it also performs Enigma-style odometer stepping on a keypress request: rotor 0 always advances, and each wrap carries into the next rotor, one rotor per cycle. The registered positions drive the cipher datapath and display.

---
 rtl/rotor_position_bank_pkg.sv | 32 +++
 rtl/rotor_position_bank_if.sv | 41 ++++
 rtl/rotor_position_bank_counter.sv | 49 ++++
 rtl/rotor_position_bank.sv | 157 +++++++++++++++
 tb/tb_rotor_position_bank.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rotor_position_bank_pkg.sv
// ============================================================================
// Module   : rotor_pkg
// Purpose  : Shared defaults, step-FSM state encoding and select helpers for
//            the rotor position bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rotor_pkg;

  // Default geometry: eight rotors, 26-letter alphabet, 5-bit positions.
  localparam int NUM_ROTORS_DEF = 8;
  localparam int ALPHA          = 26;
  localparam int POS_W          = 5;

  // Widest rotor-select vector the one-hot helper accepts.
  localparam int MAX_SEL_W = 32;

  // Odometer step FSM encoding.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CARRY  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // True when exactly one bit of the (zero-extended) select vector is set.
  function automatic logic is_onehot(input logic [MAX_SEL_W-1:0] sel);
    return ($countones(sel) == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rotor_position_bank_if.sv
// ============================================================================
// Module   : rotor_position_bank_if
// Purpose  : Select/increment/step inputs and position/status outputs of the
//            rotor position bank. master = upstream FSMs, slave = the bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rotor_position_bank_if #(
  parameter int NUM_ROTORS = 8,
  parameter int POS_W      = 5
);

  logic [NUM_ROTORS-1:0]       rotor_sel;
  logic                        increment;
  logic                        step_req;
  logic [NUM_ROTORS*POS_W-1:0] positions;
  logic                        busy;
  logic                        step_done;

  modport master (
    output rotor_sel,
    output increment,
    output step_req,
    input  positions,
    input  busy,
    input  step_done
  );

  modport slave (
    input  rotor_sel,
    input  increment,
    input  step_req,
    output positions,
    output busy,
    output step_done
  );

endinterface

`default_nettype wire

// File: rtl/rotor_position_bank_counter.sv
// ============================================================================
// Module   : rotor_counter
// Purpose  : Single rotor position: modulo-ALPHA counter with an advance
//            enable and a combinational wrap flag (at ALPHA-1 and advancing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_counter #(
  parameter int ALPHA = rotor_pkg::ALPHA,
  parameter int POS_W = rotor_pkg::POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  output logic [POS_W-1:0] pos_o,
  output logic             wrap_o
);

  localparam logic [POS_W-1:0] c_MAX = POS_W'(ALPHA - 1);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             w_at_max;

  assign w_at_max = (pos_q == c_MAX);
  assign wrap_o   = adv_i & w_at_max;
  assign pos_o    = pos_q;

  // Next position: hold, increment, or wrap from ALPHA-1 back to 0.
  always_comb begin
    pos_d = pos_q;
    if (adv_i) begin
      pos_d = w_at_max ? '0 : (pos_q + POS_W'(1));
    end
  end

  // Position register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rotor_position_bank.sv
// ============================================================================
// Module   : rotor_position_bank
// Purpose  : Bank of NUM_ROTORS letter positions. Applies manual increments
//            to the one-hot selected rotor and, when ROTOR_STEP_EN is
//            defined, performs odometer stepping one carry per cycle.
// Config   : `define ROTOR_STEP_EN to build the step FSM; otherwise
//            step_req is ignored and busy/step_done are held at 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotor_position_bank #(
  parameter int NUM_ROTORS = rotor_pkg::NUM_ROTORS_DEF,
  parameter int ALPHA      = rotor_pkg::ALPHA,
  parameter int POS_W      = rotor_pkg::POS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  rotor_position_bank_if.slave bus
);

  import rotor_pkg::*;

  // The interface instance must be parameterised with the same NUM_ROTORS
  // and POS_W as this module.

  logic [NUM_ROTORS-1:0] w_adv;
  logic [NUM_ROTORS-1:0] w_wrap;
  logic [NUM_ROTORS-1:0] w_step_adv;
  logic [NUM_ROTORS-1:0] w_manual_adv;
  logic                  w_sel_valid;
  logic                  w_manual_ok;

  assign w_sel_valid = is_onehot(MAX_SEL_W'(bus.rotor_sel));

  // Manual increment goes only to a validly selected rotor and never carries.
  always_comb begin
    w_manual_adv = '0;
    if (bus.increment && w_manual_ok && w_sel_valid) begin
      w_manual_adv = bus.rotor_sel;
    end
  end

  assign w_adv = w_step_adv | w_manual_adv;

`ifdef ROTOR_STEP_EN

  localparam int IDX_W = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_ROTORS - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Step advance depends only on registered state and step_req, so the
  // rotor wrap flags feed the next-state logic without a loop.
  always_comb begin
    w_step_adv  = '0;
    w_manual_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.step_req) begin
          w_step_adv[0] = 1'b1;
        end else begin
          w_manual_ok = 1'b1;
        end
      end
      ST_CARRY: begin
        w_step_adv[idx_q] = 1'b1;
      end
      default: begin
        w_step_adv  = '0;
        w_manual_ok = 1'b0;
      end
    endcase
  end

  // Next state: walk carries upward while rotors wrap, then one FINISH cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.step_req) begin
          if ((NUM_ROTORS > 1) && w_wrap[0]) begin
            state_d = ST_CARRY;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_CARRY: begin
        if (w_wrap[idx_q] && (idx_q < c_LAST_IDX)) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          // A wrap of the last rotor is simply dropped.
          state_d = ST_FINISH;
          idx_d   = '0;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and carry-index registers; reset abandons any walk in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy      = (state_q == ST_CARRY);
  assign bus.step_done = (state_q == ST_FINISH);

`else

  // No stepping: every cycle is open to manual increments.
  assign w_step_adv    = '0;
  assign w_manual_ok   = 1'b1;
  assign bus.busy      = 1'b0;
  assign bus.step_done = 1'b0;

  // step_req and the wrap flags have no consumer in this build.
  logic w_unused;
  assign w_unused = ^{bus.step_req, w_wrap};

`endif

  for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_rotor
    rotor_counter #(
      .ALPHA (ALPHA),
      .POS_W (POS_W)
    ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (w_adv[k]),
      .pos_o  (bus.positions[k*POS_W +: POS_W]),
      .wrap_o (w_wrap[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rotor_position_bank.sv
// ============================================================================
// Module   : tb_rotor_position_bank
// Purpose  : Directed self-checking bench for rotor_position_bank; step
//            scenarios are built when ROTOR_STEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotor_position_bank;

  localparam int NR = 8;
  localparam int PW = 5;
  localparam int AL = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rotor_position_bank_if #(.NUM_ROTORS(NR), .POS_W(PW)) bus ();

  rotor_position_bank #(
    .NUM_ROTORS (NR),
    .ALPHA      (AL),
    .POS_W      (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_pos[NR];

  function automatic logic [NR*PW-1:0] exp_vec();
    logic [NR*PW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*PW +: PW] = PW'(exp_pos[k]);
    return v;
  endfunction

  function automatic logic [NR-1:0] sel_of(input int k);
    logic [NR-1:0] s;
    s = '0;
    s[k] = 1'b1;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rotor_sel = '0;
    bus.increment = 1'b0;
    bus.step_req  = 1'b0;
    for (int k = 0; k < NR; k++) exp_pos[k] = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Bring rotor k forward by n manual increments (one per cycle).
  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rotor_sel = sel_of(k);
      bus.increment = 1'b1;
      tick();
      bus.increment = 1'b0;
      exp_pos[k] = (exp_pos[k] + 1) % AL;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.positions !== '0) begin
      n_err++;
      $display("FAIL reset_pos: got %h expected 0", bus.positions);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_vec++;
    if (bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b expected 0", bus.step_done);
    end
    do_reset();
    n_vec++;
    if (bus.positions !== '0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got pos %h busy %b done %b expected 0",
               bus.positions, bus.busy, bus.step_done);
    end
  endtask

  // 27 pulses into rotor 2, five cycles apart; the 25->0 wrap must not carry.
  task automatic test_increment_wrap();
    do_reset();
    bus.rotor_sel = 8'b0000_0100;
    for (int i = 1; i <= 27; i++) begin
      bus.increment = 1'b1;
      tick();
      bus.increment = 1'b0;
      exp_pos[2] = i % AL;
      if (i == 1 || i == 25 || i == 26 || i == 27) begin
        n_vec++;
        if (bus.positions !== exp_vec()) begin
          n_err++;
          $display("FAIL inc_wrap_%0d: got %h expected %h", i, bus.positions, exp_vec());
        end
      end
      repeat (4) tick();
    end
  endtask

  // Increments with zero or multiple select bits are dropped.
  task automatic test_invalid_sel();
    logic [NR-1:0] bad [2];
    bad[0] = 8'b0000_0110;
    bad[1] = 8'b0000_0000;
    for (int j = 0; j < 2; j++) begin
      bus.rotor_sel = bad[j];
      bus.increment = 1'b1;
      tick();
      bus.increment = 1'b0;
      tick();
      n_vec++;
      if (bus.positions !== exp_vec()) begin
        n_err++;
        $display("FAIL invalid_sel_%b: got %h expected %h", bad[j], bus.positions, exp_vec());
      end
    end
  endtask

  // Increments on consecutive cycles are each applied in IDLE.
  task automatic test_back_to_back();
    do_reset();
    load(1, 3);
    n_vec++;
    if (bus.positions !== exp_vec()) begin
      n_err++;
      $display("FAIL back_to_back: got %h expected %h", bus.positions, exp_vec());
    end
  endtask

  // step_req and increment together with rotor 7 selected, rotor 0 at 5.
  task automatic test_simultaneous();
    do_reset();
    load(0, 5);
    bus.rotor_sel = 8'b1000_0000;
    bus.increment = 1'b1;
    bus.step_req  = 1'b1;
    tick();
    bus.increment = 1'b0;
    bus.step_req  = 1'b0;
`ifdef ROTOR_STEP_EN
    exp_pos[0] = 6;
    n_vec++;
    if (bus.step_done !== 1'b1) begin
      n_err++;
      $display("FAIL simul_done: got %b expected 1", bus.step_done);
    end
`else
    exp_pos[7] = 1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL simul_status: got busy %b done %b expected 0 0", bus.busy, bus.step_done);
    end
`endif
    n_vec++;
    if (bus.positions !== exp_vec()) begin
      n_err++;
      $display("FAIL simul_pos: got %h expected %h", bus.positions, exp_vec());
    end
  endtask

`ifdef ROTOR_STEP_EN
  // Rotors 25,25,3: carries into rotors 1 and 2 on successive edges.
  task automatic test_step_carry();
    logic [NR*PW-1:0] exp_p [3];
    logic             exp_b [3];
    logic             exp_d [3];
    do_reset();
    load(0, 25);
    load(1, 25);
    load(2, 3);
    bus.rotor_sel = '0;
    tick();
    bus.step_req = 1'b1;
    exp_pos[0] = 0;  exp_p[0] = exp_vec(); exp_b[0] = 1'b1; exp_d[0] = 1'b0;
    exp_pos[1] = 0;  exp_p[1] = exp_vec(); exp_b[1] = 1'b1; exp_d[1] = 1'b0;
    exp_pos[2] = 4;  exp_p[2] = exp_vec(); exp_b[2] = 1'b0; exp_d[2] = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      bus.step_req = 1'b0;
      n_vec++;
      if (bus.positions !== exp_p[e] || bus.busy !== exp_b[e] || bus.step_done !== exp_d[e]) begin
        n_err++;
        $display("FAIL step_carry_t%0d: got pos %h busy %b done %b expected pos %h busy %b done %b",
                 e, bus.positions, bus.busy, bus.step_done, exp_p[e], exp_b[e], exp_d[e]);
      end
    end
    tick();
    n_vec++;
    if (bus.step_done !== 1'b0 || bus.positions !== exp_vec()) begin
      n_err++;
      $display("FAIL step_carry_after: got pos %h done %b expected pos %h done 0",
               bus.positions, bus.step_done, exp_vec());
    end
  endtask

  // All rotors at 25: full-length walk; requests made while busy are dropped.
  task automatic test_all_wrap();
    do_reset();
    for (int k = 0; k < NR; k++) load(k, 25);
    bus.rotor_sel = '0;
    bus.step_req  = 1'b1;
    tick();
    bus.step_req = 1'b0;
    exp_pos[0] = 0;
    for (int e = 1; e < NR; e++) begin
      if (e == 2) begin
        bus.rotor_sel = 8'b0000_0001;
        bus.increment = 1'b1;
        bus.step_req  = 1'b1;
      end
      tick();
      bus.increment = 1'b0;
      bus.step_req  = 1'b0;
      exp_pos[e] = 0;
      n_vec++;
      if (bus.positions !== exp_vec() || bus.busy !== (e < NR - 1) || bus.step_done !== (e == NR - 1)) begin
        n_err++;
        $display("FAIL all_wrap_e%0d: got pos %h busy %b done %b expected pos %h busy %b done %b",
                 e, bus.positions, bus.busy, bus.step_done, exp_vec(), (e < NR - 1), (e == NR - 1));
      end
    end
    repeat (4) tick();
    n_vec++;
    if (bus.positions !== '0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL all_wrap_settle: got pos %h busy %b done %b expected 0 0 0",
               bus.positions, bus.busy, bus.step_done);
    end
  endtask

  // Reset asserted while carrying clears everything immediately.
  task automatic test_reset_mid_carry();
    do_reset();
    load(0, 25);
    load(1, 25);
    load(2, 25);
    bus.rotor_sel = '0;
    bus.step_req  = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.positions !== '0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_carry: got pos %h busy %b done %b expected 0 0 0",
               bus.positions, bus.busy, bus.step_done);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (bus.positions !== '0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_carry_idle: got pos %h busy %b done %b expected 0 0 0",
               bus.positions, bus.busy, bus.step_done);
    end
  endtask
`endif

  initial begin
    bus.rotor_sel = '0;
    bus.increment = 1'b0;
    bus.step_req  = 1'b0;
    test_reset();
    test_increment_wrap();
    test_invalid_sel();
    test_back_to_back();
    test_simultaneous();
`ifdef ROTOR_STEP_EN
    test_step_carry();
    test_all_wrap();
    test_reset_mid_carry();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
